// File: rtl/adc_spi_responder.sv
// LTC2308-style SPI ADC target: captures a 6-bit config word on ADC_DIN and shifts out
// the held 12-bit sample of the channel that the previous frame selected.
module adc_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int CFG_W       = 6,
    parameter int CONV_CYCLES = 80
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ADC_CS_N,
    input  logic                  ADC_SCLK,
    input  logic                  ADC_DIN,
    output logic                  ADC_DOUT,
    input  logic [8*DATA_W-1:0]   ch_data,
    output logic [2:0]            channel,
    output logic [CFG_W-1:0]      cfg_word,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CONV  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_cs_sync, r_sclk_sync, r_din_sync;
    logic                r_cs_d, r_sclk_d;
    logic                r_armed;
    logic [4:0]          r_bit_cnt;
    logic [CFG_W-1:0]    r_cfg_shift;
    logic [2:0]          r_ch_next;
    logic [DATA_W-1:0]   r_snap, r_result;
    logic [CNT_W-1:0]    r_conv_cnt;

    logic                w_cs, w_din, w_cs_fall, w_cs_rise, w_sclk_rise, w_sclk_fall;
    logic                w_start, w_valid_end, w_short_end, w_conv_done, w_conv_err;
    logic [2:0]          w_cfg_ch;
    logic [DATA_W-1:0]   w_shifted;
    logic [DATA_W-1:0]   w_ch_arr [8];

    assign w_cs        = r_cs_sync[1];
    assign w_din       = r_din_sync[1];
    assign w_cs_fall   = r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_sclk_rise = ~r_sclk_d & r_sclk_sync[1];
    assign w_sclk_fall = r_sclk_d & ~r_sclk_sync[1];
    // Channel code is {S1,S0,O/S}; config word is {S/D,O/S,S1,S0,UNI,SLP}.
    assign w_cfg_ch    = {r_cfg_shift[CFG_W-3], r_cfg_shift[CFG_W-4], r_cfg_shift[CFG_W-2]};
    assign w_shifted   = r_result << r_bit_cnt;

    for (genvar g = 0; g < 8; g++) begin : g_ch
        assign w_ch_arr[g] = ch_data[g*DATA_W +: DATA_W];
    end

    // Pin synchronizers and edge-detect history.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cs_sync   <= 2'b00;
            r_sclk_sync <= 2'b00;
            r_din_sync  <= 2'b00;
            r_cs_d      <= 1'b0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], ADC_CS_N};
            r_sclk_sync <= {r_sclk_sync[0], ADC_SCLK};
            r_din_sync  <= {r_din_sync[0], ADC_DIN};
            r_cs_d      <= r_cs_sync[1];
            r_sclk_d    <= r_sclk_sync[1];
        end
    end

    // Frame state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and frame event decode.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_valid_end  = 1'b0;
        w_short_end  = 1'b0;
        w_conv_done  = 1'b0;
        w_conv_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_start      = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_cs_rise && (r_bit_cnt >= 5'(CFG_W))) begin
                    w_valid_end  = 1'b1;
                    w_state_next = S_CONV;
                end else if (w_cs_rise) begin
                    w_short_end  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_SHIFT;
                end
            end
            S_CONV: begin
                w_conv_err = w_cs_fall;
                if (r_conv_cnt == CNT_W'(CONV_CYCLES - 1)) begin
                    w_conv_done  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_CONV;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Shift path, sample-and-hold, conversion timer and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_armed     <= 1'b0;
            r_bit_cnt   <= 5'd0;
            r_cfg_shift <= '0;
            r_ch_next   <= 3'd0;
            r_snap      <= '0;
            r_result    <= '0;
            r_conv_cnt  <= '0;
            ADC_DOUT    <= 1'b0;
            channel     <= 3'd0;
            cfg_word    <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_armed    <= r_armed | w_cs;
            frame_done <= w_valid_end;
            frame_err  <= w_short_end | w_conv_err;

            if (w_start) begin
                r_bit_cnt   <= 5'd0;
                r_cfg_shift <= '0;
                ADC_DOUT    <= r_result[DATA_W-1];
            end else if (r_state == S_SHIFT && !w_cs_rise) begin
                if (w_sclk_rise) begin
                    if (r_bit_cnt < 5'(CFG_W)) begin
                        r_cfg_shift <= {r_cfg_shift[CFG_W-2:0], w_din};
                    end
                    if (r_bit_cnt != 5'd31) begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                // Shifting left runs out to zeros once bit_cnt reaches DATA_W.
                if (w_sclk_fall) begin
                    ADC_DOUT <= w_shifted[DATA_W-1];
                end
            end

            if (w_valid_end) begin
                cfg_word   <= r_cfg_shift;
                r_ch_next  <= w_cfg_ch;
                r_snap     <= w_ch_arr[w_cfg_ch];
                r_conv_cnt <= '0;
                ADC_DOUT   <= 1'b0;
            end else if (r_state == S_CONV) begin
                r_conv_cnt <= r_conv_cnt + 1'b1;
            end

            if (w_short_end) begin
                ADC_DOUT <= 1'b0;
            end

            if (w_conv_done) begin
                r_result <= cfg_word[0] ? '0 : r_snap;
                channel  <= r_ch_next;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized bench for adc_spi_responder against a frame-level model of the ADC pipeline.
module tb_adc_spi_responder;

    localparam int DATA_W      = 12;
    localparam int CFG_W       = 6;
    localparam int CONV_CYCLES = 80;
    localparam int HALF        = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs_n  = 1'b1;
    logic        sclk  = 1'b0;
    logic        din   = 1'b0;
    logic        dout;
    logic [95:0] ch_data = '0;
    logic [2:0]  channel;
    logic [5:0]  cfg_word;
    logic        frame_done, frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    logic width_bad = 1'b0;

    // Frame-level model: held result, pending conversion, last config.
    logic [11:0] m_result  = 12'h000;
    logic [11:0] m_pending = 12'h000;
    logic [2:0]  m_channel = 3'd0;
    logic [2:0]  m_pend_ch = 3'd0;
    logic [5:0]  m_cfg     = 6'h00;
    bit          m_in_conv = 1'b0;

    adc_spi_responder #(
        .DATA_W(DATA_W), .CFG_W(CFG_W), .CONV_CYCLES(CONV_CYCLES)
    ) dut (
        .clock(clock), .reset(reset),
        .ADC_CS_N(cs_n), .ADC_SCLK(sclk), .ADC_DIN(din), .ADC_DOUT(dout),
        .ch_data(ch_data), .channel(channel), .cfg_word(cfg_word),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clock = ~clock;

    // Pulse counter; any pulse longer than one cycle is flagged.
    always @(negedge clock) begin
        prev_done <= frame_done;
        prev_err  <= frame_err;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if ((frame_done && prev_done) || (frame_err && prev_err)) width_bad <= 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    function automatic logic [11:0] ch_val(input logic [2:0] c);
        return ch_data[c*12 +: 12];
    endfunction

    function automatic logic [2:0] cfg_ch(input logic [5:0] c);
        return {c[3], c[2], c[4]};
    endfunction

    task automatic commit_conv();
        if (m_in_conv) begin
            m_result  = m_pending;
            m_channel = m_pend_ch;
            m_in_conv = 1'b0;
        end
    endtask

    task automatic wait_conv();
        wait_clk(CONV_CYCLES + 20);
        commit_conv();
        chk("channel_after_conv", 32'(channel), 32'(m_channel));
    endtask

    // One SPI frame of nrises SCLK cycles; DOUT sampled just before each rise.
    task automatic run_frame(input logic [5:0] cfg, input int nrises,
                             input bit lit, input logic [11:0] lit_dout);
        logic [15:0] got;
        logic [15:0] exp;
        int d0, e0;
        bit busy, valid;
        got   = 16'h0000;
        exp   = 16'h0000;
        busy  = m_in_conv;
        valid = !busy && (nrises >= CFG_W);
        for (int i = 0; i < nrises; i++) begin
            exp[15-i] = (busy || i >= DATA_W) ? 1'b0 : m_result[11-i];
        end
        d0 = done_cnt;
        e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nrises; i++) begin
            din = (i < CFG_W) ? cfg[5-i] : 1'($urandom_range(0, 1));
            wait_clk(HALF);
            got[15-i] = dout;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(HALF);
        chk("dout_bits", 32'(got), 32'(exp));
        if (lit) chk("dout_literal", 32'(got), 32'({lit_dout, 4'b0000}));
        chk("frame_done_pulses", 32'(done_cnt - d0), valid ? 32'd1 : 32'd0);
        chk("frame_err_pulses", 32'(err_cnt - e0), valid ? 32'd0 : 32'd1);
        chk("pulse_width", 32'(width_bad), 32'd0);
        if (valid) begin
            m_cfg     = cfg;
            m_pend_ch = cfg_ch(cfg);
            m_pending = cfg[0] ? 12'h000 : ch_val(cfg_ch(cfg));
            m_in_conv = 1'b1;
            chk("channel_held_in_conv", 32'(channel), 32'(m_channel));
        end
        chk("cfg_word", 32'(cfg_word), 32'(m_cfg));
        if (busy) wait_conv();
    endtask

    initial begin
        logic any_dout;
        int d0, e0, nr, r;
        logic [5:0] cfg;

        for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = 12'($urandom);
        ch_data[11:0] = 12'hA5C;

        wait_clk(5);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_channel", 32'(channel), 32'd0);
        chk("rst_cfg", 32'(cfg_word), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        reset = 1'b0;
        wait_clk(5);

        // Directed sequence with hand-computed expectations.
        run_frame(6'b100010, 16, 1'b1, 12'h000);
        chk("cfg_literal_22", 32'(cfg_word), 32'h22);
        wait_conv();
        ch_data[5*12 +: 12] = 12'h123;
        run_frame(6'b111010, 16, 1'b1, 12'hA5C);
        wait_conv();
        chk("channel_literal_5", 32'(channel), 32'd5);
        run_frame(6'b101010, 2, 1'b0, 12'h000);
        chk("cfg_after_short", 32'(cfg_word), 32'h3A);
        run_frame(6'b100010, 16, 1'b1, 12'h123);
        wait_clk(2);
        run_frame(6'b100011, 16, 1'b1, 12'h000);
        run_frame(6'b100011, 16, 1'b1, 12'hA5C);
        wait_conv();
        run_frame(6'b100010, 16, 1'b1, 12'h000);
        wait_conv();

        // Reset in the middle of a frame with CS_N held low.
        d0 = done_cnt;
        e0 = err_cnt;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            wait_clk(HALF);
            if (i < 2) begin
                sclk = 1'b0;
                wait_clk(HALF);
            end
        end
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
        m_result = 12'h000; m_pending = 12'h000; m_channel = 3'd0;
        m_pend_ch = 3'd0; m_cfg = 6'h00; m_in_conv = 1'b0;
        chk("midrst_dout", 32'(dout), 32'd0);
        chk("midrst_channel", 32'(channel), 32'd0);
        chk("midrst_cfg", 32'(cfg_word), 32'd0);
        sclk = 1'b0;
        any_dout = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wait_clk(HALF);
            any_dout = any_dout | dout;
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(HALF);
        chk("midrst_dout_quiet", 32'(any_dout), 32'd0);
        chk("midrst_no_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        run_frame(6'b100010, 16, 1'b1, 12'h000);
        wait_conv();

        // Randomized frames: full, partial-valid, short, and ones overlapping CONV.
        for (int it = 0; it < 24; it++) begin
            for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = 12'($urandom);
            cfg = 6'($urandom_range(0, 63));
            r = $urandom_range(0, 9);
            if (r < 7)       nr = 16;
            else if (r == 7) nr = $urandom_range(6, 11);
            else             nr = $urandom_range(1, 5);
            run_frame(cfg, nr, 1'b0, 12'h000);
            if (m_in_conv) begin
                if ($urandom_range(0, 3) == 0) begin
                    wait_clk(2);
                    for (int n = 0; n < 8; n++) ch_data[n*12 +: 12] = 12'($urandom);
                end else begin
                    wait_conv();
                end
            end
        end
        if (m_in_conv) wait_conv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
